// File: rtl/demod_pkg.sv
// demod_pkg: shared constants, FSM states and reference lookups for the segment demodulator.
package demod_pkg;
  localparam int NUM_SEG = 10;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] REF_POS = 32'h0001_0000;
  localparam logic [DATA_W-1:0] REF_NEG = 32'hFFFF_0000;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic [DATA_W-1:0] ref_of(input logic [3:0] i);
    return i[0] ? REF_NEG : REF_POS;
  endfunction
  function automatic logic [DATA_W-1:0] ref_m_of(input logic [3:0] i);
    return i[0] ? REF_POS : REF_NEG;
  endfunction
endpackage

// File: rtl/demod_decision_slice.sv
// demod_decision_slice: registered sign decision picking ref or ref_m for one segment index.
module demod_decision_slice
  import demod_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic [3:0]        idx,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] result_d, result_q;
  // zero is not positive, so it takes ref_m
  always_comb result_d = ($signed(sample) > 0) ? ref_of(idx) : ref_m_of(idx);
  always_ff @(posedge clk) result_q <= reset ? '0 : result_d;
  assign result = result_q;
endmodule

// File: rtl/demod_segment_scheduler.sv
// demod_segment_scheduler: steps one shared decision slice over all segments and banks the results.
module demod_segment_scheduler
  import demod_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_W-1:0]         input_bit,
  output logic [NUM_SEG*DATA_W-1:0] segment_bus,
  output logic [3:0]                seg_idx,
  output logic                      seg_we,
  output logic                      valid,
  output logic                      busy
);
  state_t state_d, state_q;
  logic [3:0] idx_d, idx_q, seg_idx_d, seg_idx_q;
  logic [DATA_W-1:0] sample_d, sample_q, result;
  logic seg_we_d, seg_we_q;
  logic [NUM_SEG*DATA_W-1:0] bank_d, bank_q;
  demod_decision_slice u_slice (
    .clk    (clk),
    .reset  (reset),
    .sample (sample_q),
    .idx    (idx_q),
    .result (result)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sample_d = sample_q;
    bank_d = bank_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        idx_d = '0;
        sample_d = input_bit;
      end
      RUN: begin
        state_d = (idx_q == 4'(NUM_SEG - 1)) ? DRAIN : RUN;
        idx_d = (idx_q == 4'(NUM_SEG - 1)) ? idx_q : idx_q + 4'd1;
      end
      DRAIN: state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    // slice output lags idx by one cycle, so the strobe and its index are delayed to match
    seg_we_d = (state_q == RUN);
    seg_idx_d = (state_q == RUN) ? idx_q : seg_idx_q;
    if (seg_we_q) bank_d[seg_idx_q*DATA_W +: DATA_W] = result;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      sample_q <= '0;
      seg_we_q <= 1'b0;
      seg_idx_q <= '0;
      bank_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sample_q <= sample_d;
      seg_we_q <= seg_we_d;
      seg_idx_q <= seg_idx_d;
      bank_q <= bank_d;
    end
  end
  assign segment_bus = bank_q;
  assign seg_idx = seg_idx_q;
  assign seg_we = seg_we_q;
  assign valid = (state_q == DONE);
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_demod_segment_scheduler.sv
// tb_demod_segment_scheduler: directed checks of segment values, strobe sequence, timing and reset abort.
module tb_demod_segment_scheduler;
  logic clk = 1'b0;
  logic reset, start;
  logic [31:0] input_bit;
  logic [319:0] segment_bus;
  logic [3:0] seg_idx;
  logic seg_we, valid, busy;
  int n_cmp = 0;
  int n_err = 0;
  demod_segment_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .input_bit   (input_bit),
    .segment_bus (segment_bus),
    .seg_idx     (seg_idx),
    .seg_we      (seg_we),
    .valid       (valid),
    .busy        (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_segs(input string tag, input bit pos);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s seg%0d", tag, i), segment_bus[i*32 +: 32],
          (pos ^ (i % 2 == 1)) ? 32'h0001_0000 : 32'hFFFF_0000);
  endtask
  task automatic chk_zero(input string tag);
    for (int i = 0; i < 10; i++) chk($sformatf("%s seg%0d", tag, i), segment_bus[i*32 +: 32], 32'h0);
  endtask
  // called at a negedge with DUT idle; returns at the negedge of T+13
  task automatic do_run(input string tag, input logic [31:0] s, input bit pos);
    start = 1'b1;
    input_bit = s;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) input_bit = ~s;
      chk($sformatf("%s busy k%0d", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s we k%0d", tag, k), 32'(seg_we), 32'(k >= 2 && k <= 11));
      if (k >= 2 && k <= 11) chk($sformatf("%s idx k%0d", tag, k), 32'(seg_idx), 32'(k - 2));
      chk($sformatf("%s valid k%0d", tag, k), 32'(valid), 32'(k == 12));
      if (k == 12) chk_segs(tag, pos);
      @(negedge clk);
    end
    chk($sformatf("%s busy end", tag), 32'(busy), 32'd0);
    chk($sformatf("%s valid end", tag), 32'(valid), 32'd0);
    chk_segs($sformatf("%s hold", tag), pos);
  endtask
  initial begin
    int rise[$];
    int nvalid;
    logic pbusy;
    reset = 1'b1;
    start = 1'b0;
    input_bit = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst we", 32'(seg_we), 32'd0);
    chk("rst idx", 32'(seg_idx), 32'd0);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    do_run("t1", 32'h0002_0000, 1'b1);
    do_run("t2", 32'hFFFE_0000, 1'b0);
    do_run("t3a", 32'h0000_0000, 1'b0);
    do_run("t3b", 32'h8000_0000, 1'b0);
    do_run("t6p", 32'h0000_0001, 1'b1);
    do_run("t6n", 32'hFFFF_FFFF, 1'b0);
    // start held: only accepts in IDLE, so two runs in 26 cycles
    nvalid = 0;
    pbusy = 1'b0;
    input_bit = 32'h0002_0000;
    for (int c = 0; c < 45; c++) begin
      start = (c < 26);
      @(negedge clk);
      if (busy && !pbusy) rise.push_back(c);
      if (valid) nvalid++;
      pbusy = busy;
    end
    start = 1'b0;
    chk("t4 valids", 32'(nvalid), 32'd2);
    chk("t4 accepts", 32'(rise.size()), 32'd2);
    if (rise.size() == 2) chk("t4 spacing", 32'(rise[1] - rise[0]), 32'd13);
    chk_segs("t4", 1'b1);
    // reset during RUN
    start = 1'b1;
    input_bit = 32'hFFFE_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5 busy pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 we", 32'(seg_we), 32'd0);
    chk_zero("t5");
    nvalid = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid || busy) nvalid++;
    end
    chk("t5 quiet", 32'(nvalid), 32'd0);
    do_run("t5 fresh", 32'h0002_0000, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
